elephant_ise_inv: RTL and testbench
===================================

Name: elephant_ise_inv

Overview:
- Multi-cycle inverse engine for the Elephant/Spongent ISE layer operations.
- Undoes the forward S-layer step (sstep: nibble SBOX then four delta-swaps) and the forward p-step (pstep_x/pstep_y, imm 0..6).
- Sits beside the combinational forward ISE as a request/response co-unit in the rv32 datapath. Used for software decryption experiments, self-test and round-trip checks.
- Iterative: one delta-swap per cycle, which keeps its area below the forward unit.

Parameters:
- none (all masks and shift amounts are fixed constants from the shared package)

Ports:
- g_clk      in   1   clock
- g_resetn   in   1   asynchronous active-low reset
- flush      in   1   synchronous abort; discards any in-flight operation
- req_valid  in   1   request present
- req_ready  out  1   engine idle, can accept a request
- req_op     in   2   0=inv_sstep, 1=inv_pstep_x, 2=inv_pstep_y, 3=reserved
- req_imm    in   3   p-step selector 0..7 (ignored for inv_sstep)
- req_rs1    in   32  sstep output (inv_sstep) or x' as produced by forward pstep (inv_pstep)
- req_rs2    in   32  y' (inv_pstep only)
- rsp_valid  out  1   result available
- rsp_ready  in   1   consumer takes result
- rsp_rd     out  32  result

Behaviour:
- One clock g_clk. Reset is asynchronous, active-low (g_resetn).
- Reset values:
  - FSM=IDLE, req_ready=1, rsp_valid=0, rsp_rd=0
  - internal x/y/t registers=0, swap counter=0
- FSM states: IDLE, PERM, SBOX, DONE.
- req_ready = (state==IDLE) && !flush. Accept on req_valid && req_ready.
- Accept in IDLE:
  - Latch op, imm, x=rs1, y=rs2.
  - op=3, or inv_pstep with imm=7 -> go to DONE with rsp_rd=0.
  - Otherwise -> PERM with cnt=0.
- PERM, inv_sstep (4 cycles, cnt 0..3): apply swapmv(x,mask,N) in reverse order:
  - cnt 0: mask 0x0000FF00, N 8
  - cnt 1: mask 0x0000F0F0, N 12
  - cnt 2: mask 0x00CC00CC, N 6
  - cnt 3: mask 0x0A0A0A0A, N 3
  - swapmv: t=(x^(x>>N))&mask; x := x^t^(t<<N). Logical shifts, 32-bit truncation. The swap is self-inverse.
  - After cnt 3 -> SBOX.
- SBOX (1 cycle): each of the 8 nibbles is replaced by INV_SBOX, result to rsp_rd, -> DONE.
  - INV_SBOX[0..F] = 3,5,4,E,6,B,F,8,A,C,9,2,D,1,0,7.
- PERM, inv_pstep (1 cycle):
  - First un-rotate x for imm4/5/6: rotr 8, 16, 24 respectively. imm0..3 use no rotation.
  - Then t=(y^(x>>N))&mask with (mask,N) per imm:
    - 0: (0x000000FF, 8)
    - 1: (0x000000FF, 16)
    - 2: (0x000000FF, 24)
    - 3: (0x0000FF00, 8)
    - 4: (0x000000FF, 24)
    - 5: (0x0000FF00, 16)
    - 6: (0x00FF0000, 8)
  - Result: inv_pstep_x -> x^(t<<N); inv_pstep_y -> y^t.
  - Write result to rsp_rd, -> DONE.
- DONE: rsp_valid=1 and rsp_rd holds stable. rsp_ready -> IDLE, rsp_valid=0 on the same edge.
  - Back-to-back accept is not possible: req_ready is low in DONE, so the minimum gap is one IDLE cycle.
- Latency, counted from the accept edge to the edge that raises rsp_valid:
  - inv_sstep: 5 edges
  - inv_pstep: 1 edge
  - reserved op / imm=7: 0 extra edges (DONE directly at accept)
- flush has highest priority in any state: -> IDLE, rsp_valid=0. rsp_rd keeps its last value; it is don't-care while rsp_valid=0.
- req_valid while busy is ignored. The requester must hold its inputs until req_ready.
- Asynchronous reset mid-operation returns to the reset values immediately; no response is produced.
- rsp_ready while not in DONE has no effect.

Decomposition:
- Package elephant_ise_pkg holds:
  - op encodings
  - FSM state encoding
  - inv_sstep mask/shift constants in application order
  - pstep mask/shift/rotate tables indexed by imm
  - INV_SBOX function
- Sub-module elephant_inv_sbox: combinational 32-bit, 8-nibble inverse SBOX layer, instantiated once in the SBOX stage.

Test Plan:
- Reset: assert g_resetn=0 mid inv_sstep -> immediately req_ready=1, rsp_valid=0, rsp_rd=0; no response ever follows.
- inv_sstep rs1=0x00000000 -> rsp_rd=0x33333333, rsp_valid rises 5 edges after accept.
- inv_sstep rs1=0xFFFFFFFF -> rsp_rd=0x77777777.
- inv_pstep, imm=0, rs1=0x00000100, rs2=0:
  - op x -> rsp_rd=0x00000000
  - op y -> rsp_rd=0x00000001
  - both after 1 edge
- inv_pstep imm=7 with any rs1/rs2 -> rsp_rd=0, rsp_valid asserted the cycle after accept.
- Flush and back-pressure:
  - flush asserted in PERM cnt=2 -> IDLE next edge, rsp_valid never rises, next request completes normally.
  - rsp_ready held low 10 cycles in DONE -> rsp_rd stable and req_ready=0 throughout.
- Random round-trip (1000 vectors) against the forward ISE model:
  - inv_sstep(sstep(v)) == v.
  - For imm 0..6: inv_pstep_x/y applied to forward (x',y') returns the original x/y.

Source files
------------

// File: rtl/elephant_ise_pkg.sv
// Shared constants, encodings and helpers for the Elephant/Spongent inverse ISE engine.
package elephant_ise_pkg;

  typedef enum logic [1:0] {
    OP_INV_SSTEP   = 2'd0,
    OP_INV_PSTEP_X = 2'd1,
    OP_INV_PSTEP_Y = 2'd2,
    OP_RSVD        = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PERM = 2'd1,
    ST_SBOX = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Delta-swaps undoing the forward sstep, listed in the order they are applied.
  localparam logic [31:0] SSTEP_MASK  [4] = '{32'h0000FF00, 32'h0000F0F0,
                                              32'h00CC00CC, 32'h0A0A0A0A};
  localparam logic [4:0]  SSTEP_SHIFT [4] = '{5'd8, 5'd12, 5'd6, 5'd3};

  // p-step tables indexed by imm; entry 7 is the invalid selector and never used.
  localparam logic [31:0] PSTEP_MASK  [8] = '{32'h000000FF, 32'h000000FF, 32'h000000FF,
                                              32'h0000FF00, 32'h000000FF, 32'h0000FF00,
                                              32'h00FF0000, 32'h00000000};
  localparam logic [4:0]  PSTEP_SHIFT [8] = '{5'd8, 5'd16, 5'd24, 5'd8,
                                              5'd24, 5'd16, 5'd8, 5'd0};
  localparam logic [4:0]  PSTEP_ROTR  [8] = '{5'd0, 5'd0, 5'd0, 5'd0,
                                              5'd8, 5'd16, 5'd24, 5'd0};

  localparam logic [2:0] IMM_INVALID = 3'd7;

  // Inverse of the Spongent 4-bit S-box.
  function automatic logic [3:0] inv_sbox(input logic [3:0] n);
    case (n)
      4'h0: inv_sbox = 4'h3;
      4'h1: inv_sbox = 4'h5;
      4'h2: inv_sbox = 4'h4;
      4'h3: inv_sbox = 4'hE;
      4'h4: inv_sbox = 4'h6;
      4'h5: inv_sbox = 4'hB;
      4'h6: inv_sbox = 4'hF;
      4'h7: inv_sbox = 4'h8;
      4'h8: inv_sbox = 4'hA;
      4'h9: inv_sbox = 4'hC;
      4'hA: inv_sbox = 4'h9;
      4'hB: inv_sbox = 4'h2;
      4'hC: inv_sbox = 4'hD;
      4'hD: inv_sbox = 4'h1;
      4'hE: inv_sbox = 4'h0;
      default: inv_sbox = 4'h7;
    endcase
  endfunction

  // Self-inverse delta-swap of bit pairs (i, i+n) selected by mask.
  function automatic logic [31:0] swapmv(input logic [31:0] x, input logic [31:0] mask,
                                         input logic [4:0] n);
    logic [31:0] t;
    t = (x ^ (x >> n)) & mask;
    swapmv = x ^ t ^ (t << n);
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] r);
    logic [63:0] d;
    d = {x, x} >> r;
    rotr32 = d[31:0];
  endfunction

endpackage

// File: rtl/elephant_inv_sbox.sv
// Combinational inverse S-box layer over all eight nibbles of a word.
module elephant_inv_sbox
  import elephant_ise_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Substitute each nibble independently.
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      dout[4*i +: 4] = inv_sbox(din[4*i +: 4]);
    end
  end

endmodule

// File: rtl/elephant_ise_inv.sv
// Iterative inverse engine for the Elephant/Spongent sstep and pstep ISE operations.
module elephant_ise_inv
  import elephant_ise_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [2:0]  req_imm,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd
);

  state_t      state_q, state_d;
  op_t         op_q, req_op_e;
  logic [2:0]  imm_q;
  logic [31:0] x_q, y_q;
  logic [1:0]  cnt_q;
  logic [31:0] rd_q;

  logic        accept;
  logic        bypass;
  logic [31:0] swap_x;
  logic [31:0] sbox_out;
  logic [31:0] x_r, pt, px, py;

  assign req_op_e  = op_t'(req_op);
  assign req_ready = (state_q == ST_IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign bypass    = (req_op_e == OP_RSVD) ||
                     ((req_op_e != OP_INV_SSTEP) && (req_imm == IMM_INVALID));
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_rd    = rd_q;

  assign swap_x = swapmv(x_q, SSTEP_MASK[cnt_q], SSTEP_SHIFT[cnt_q]);

  elephant_inv_sbox u_sbox (
    .din  (x_q),
    .dout (sbox_out)
  );

  // Single-cycle inverse p-step: un-rotate x, then undo the x/y byte swap.
  always_comb begin
    x_r = rotr32(x_q, PSTEP_ROTR[imm_q]);
    pt  = (y_q ^ (x_r >> PSTEP_SHIFT[imm_q])) & PSTEP_MASK[imm_q];
    px  = x_r ^ (pt << PSTEP_SHIFT[imm_q]);
    py  = y_q ^ pt;
  end

  // State register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic; flush overrides every state.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid) state_d = bypass ? ST_DONE : ST_PERM;
        ST_PERM: begin
          if (op_q != OP_INV_SSTEP) state_d = ST_DONE;
          else if (cnt_q == 2'd3)   state_d = ST_SBOX;
        end
        ST_SBOX: state_d = ST_DONE;
        ST_DONE: if (rsp_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Operand latch, swap iteration and result register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      op_q  <= OP_INV_SSTEP;
      imm_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
      rd_q  <= '0;
    end else if (!flush) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= req_op_e;
            imm_q <= req_imm;
            x_q   <= req_rs1;
            y_q   <= req_rs2;
            cnt_q <= '0;
            if (bypass) rd_q <= '0;
          end
        end
        ST_PERM: begin
          if (op_q == OP_INV_SSTEP) begin
            x_q   <= swap_x;
            cnt_q <= cnt_q + 2'd1;
          end else begin
            rd_q <= (op_q == OP_INV_PSTEP_X) ? px : py;
          end
        end
        ST_SBOX: rd_q <= sbox_out;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_elephant_ise_inv.sv
// Self-checking bench for elephant_ise_inv: directed table, corner sequences, random round-trips.
module tb_elephant_ise_inv;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [2:0]  req_imm = '0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rd;

  int checks = 0;
  int errors = 0;

  elephant_ise_inv dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_imm   (req_imm),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rd    (rsp_rd)
  );

  always #5 g_clk = ~g_clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Forward reference model: Spongent S-box and bit-pair swaps written bit by bit.
  function automatic logic [3:0] fwd_sbox(input logic [3:0] n);
    logic [3:0] tbl [16] = '{4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
                             4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6};
    return tbl[n];
  endfunction

  function automatic logic [31:0] bit_swap(input logic [31:0] v, input logic [31:0] m, input int n);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < 32; i++)
      if (m[i]) begin
        r[i]     = v[i + n];
        r[i + n] = v[i];
      end
    return r;
  endfunction

  function automatic logic [31:0] fwd_sstep(input logic [31:0] v);
    logic [31:0] s;
    for (int i = 0; i < 8; i++) s[4*i +: 4] = fwd_sbox(v[4*i +: 4]);
    s = bit_swap(s, 32'h0A0A0A0A, 3);
    s = bit_swap(s, 32'h00CC00CC, 6);
    s = bit_swap(s, 32'h0000F0F0, 12);
    s = bit_swap(s, 32'h0000FF00, 8);
    return s;
  endfunction

  task automatic fwd_pstep(input int imm, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] xo, output logic [31:0] yo);
    logic [31:0] masks [7] = '{32'h000000FF, 32'h000000FF, 32'h000000FF, 32'h0000FF00,
                               32'h000000FF, 32'h0000FF00, 32'h00FF0000};
    int shifts [7] = '{8, 16, 24, 8, 24, 16, 8};
    int rots   [7] = '{0, 0, 0, 0, 8, 16, 24};
    logic [31:0] m;
    m = masks[imm];
    xo = x;
    yo = y;
    for (int i = 0; i < 32; i++)
      if (m[i]) begin
        xo[i + shifts[imm]] = y[i];
        yo[i]               = x[i + shifts[imm]];
      end
    for (int k = 0; k < rots[imm]; k++) xo = {xo[30:0], xo[31]};
  endtask

  // Issue one request, measure edges from accept to rsp_valid, then take the response.
  task automatic run_op(input logic [1:0] op, input logic [2:0] imm, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] rd, output int lat);
    int guard;
    guard = 0;
    @(negedge g_clk);
    while (!req_ready && guard < 50) begin
      @(negedge g_clk);
      guard++;
    end
    if (!req_ready) begin
      errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    req_valid = 1'b1;
    req_op    = op;
    req_imm   = imm;
    req_rs1   = a;
    req_rs2   = b;
    @(posedge g_clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge g_clk);
      #1 lat++;
    end
    rd = rsp_rd;
    rsp_ready = 1'b1;
    @(posedge g_clk);
    #1 rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;
    int          lat;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [31:0] rd, v, x, y, xp, yp, hold;
    int lat, imm;
    bit seen;

    tbl[0] = '{2'd0, 3'd0, 32'h00000000, 32'h00000000, 32'h33333333, 5};
    tbl[1] = '{2'd0, 3'd5, 32'hFFFFFFFF, 32'h12345678, 32'h77777777, 5};
    tbl[2] = '{2'd1, 3'd0, 32'h00000100, 32'h00000000, 32'h00000000, 1};
    tbl[3] = '{2'd2, 3'd0, 32'h00000100, 32'h00000000, 32'h00000001, 1};
    tbl[4] = '{2'd1, 3'd7, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 0};
    tbl[5] = '{2'd3, 3'd2, 32'hDEADBEEF, 32'hCAFEF00D, 32'h00000000, 0};
    tbl[6] = '{2'd2, 3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0};

    #12;
    check("reset_req_ready", {31'b0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_rd", rsp_rd, 32'd0);
    @(negedge g_clk);
    g_resetn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].op, tbl[i].imm, tbl[i].rs1, tbl[i].rs2, rd, lat);
      check($sformatf("vec%0d_rd", i), rd, tbl[i].rd);
      check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
    end

    // Flush while the swap counter is at 2.
    @(negedge g_clk);
    req_valid = 1'b1;
    req_op    = 2'd0;
    req_rs1   = 32'hA5A5A5A5;
    @(posedge g_clk);
    #1 req_valid = 1'b0;
    @(posedge g_clk);
    @(posedge g_clk);
    #1 flush = 1'b1;
    @(posedge g_clk);
    #1;
    check("flush_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("flush_req_ready_low", {31'b0, req_ready}, 32'd0);
    flush = 1'b0;
    #1;
    check("flush_idle_ready", {31'b0, req_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge g_clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("flush_no_response", {31'b0, seen}, 32'd0);
    run_op(2'd0, 3'd0, 32'h00000000, 32'h0, rd, lat);
    check("post_flush_rd", rd, 32'h33333333);

    // Back-pressure: hold the response for 10 cycles.
    fwd_pstep(3, 32'h11223344, 32'h55667788, xp, yp);
    @(negedge g_clk);
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_imm   = 3'd3;
    req_rs1   = xp;
    req_rs2   = yp;
    @(posedge g_clk);
    #1 req_valid = 1'b0;
    @(posedge g_clk);
    #1;
    check("bp_valid", {31'b0, rsp_valid}, 32'd1);
    hold = rsp_rd;
    check("bp_rd", hold, 32'h11223344);
    for (int i = 0; i < 10; i++) begin
      @(negedge g_clk);
      check($sformatf("bp_stable%0d", i), rsp_rd, 32'h11223344);
      check($sformatf("bp_ready_low%0d", i), {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge g_clk);
    #1 rsp_ready = 1'b0;
    check("bp_release", {31'b0, rsp_valid}, 32'd0);

    // Asynchronous reset in the middle of an inverse sstep.
    run_op(2'd2, 3'd0, 32'h00000100, 32'h0, rd, lat);
    check("pre_reset_rd", rd, 32'h00000001);
    @(negedge g_clk);
    req_valid = 1'b1;
    req_op    = 2'd0;
    req_rs1   = 32'h0F0F0F0F;
    @(posedge g_clk);
    #1 req_valid = 1'b0;
    @(posedge g_clk);
    #1 g_resetn = 1'b0;
    #1;
    check("midreset_req_ready", {31'b0, req_ready}, 32'd1);
    check("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("midreset_rsp_rd", rsp_rd, 32'd0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge g_clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("midreset_no_response", {31'b0, seen}, 32'd0);

    // Random round-trips through the forward model.
    for (int i = 0; i < 1000; i++) begin
      v = $urandom;
      run_op(2'd0, 3'($urandom_range(0, 7)), fwd_sstep(v), $urandom, rd, lat);
      check("rt_sstep", rd, v);
      imm = $urandom_range(0, 6);
      x = $urandom;
      y = $urandom;
      fwd_pstep(imm, x, y, xp, yp);
      run_op(2'd1, 3'(imm), xp, yp, rd, lat);
      check($sformatf("rt_pstep_x_imm%0d", imm), rd, x);
      run_op(2'd2, 3'(imm), xp, yp, rd, lat);
      check($sformatf("rt_pstep_y_imm%0d", imm), rd, y);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
